// File: rtl/ecc_host_link.sv
// Host end of the ECC core bit-serial link: parallel jobs out MSB-first, result frames in.
// TX frames start one cycle after acceptance; RX done one cycle after the last bit; requests stall on *_ack_rdy.

module ecc_rx_deser #(
  parameter int MAX_BITS = 256,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cur_mode,
  input  logic                valid,
  input  logic                bit_x,
  input  logic                bit_y,
  output logic [MAX_BITS-1:0] res_x,
  output logic [MAX_BITS-1:0] res_y,
  output logic                done,
  output logic                trunc
);

  function automatic logic [CNT_W:0] nbits(input logic [1:0] m);
    return (CNT_W+1)'(32) << m;
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [1:0]          frame_mode;
  logic [1:0]          eff_mode;
  logic [MAX_BITS-2:0] sh_x;
  logic [MAX_BITS-2:0] sh_y;
  logic [MAX_BITS-1:0] nx;
  logic [MAX_BITS-1:0] ny;
  logic [MAX_BITS-1:0] mask;
  logic [CNT_W:0]      n;
  logic                last;

  // Frame length is fixed when the first bit arrives; later mode changes wait for the next frame.
  always_comb begin
    eff_mode = (cnt == '0) ? cur_mode : frame_mode;
    n        = nbits(eff_mode);
    last     = ({1'b0, cnt} == (n - (CNT_W+1)'(1)));
    mask     = ~({MAX_BITS{1'b1}} << n);
    nx       = {sh_x, bit_x};
    ny       = {sh_y, bit_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_mode <= '0;
      sh_x       <= '0;
      sh_y       <= '0;
      res_x      <= '0;
      res_y      <= '0;
      done       <= 1'b0;
      trunc      <= 1'b0;
    end else begin
      done  <= 1'b0;
      trunc <= 1'b0;
      if (valid) begin
        if (cnt == '0) frame_mode <= cur_mode;
        sh_x <= nx[MAX_BITS-2:0];
        sh_y <= ny[MAX_BITS-2:0];
        if (last) begin
          res_x <= nx & mask;
          res_y <= ny & mask;
          done  <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt != '0) begin
        trunc <= 1'b1;
        cnt   <= '0;
      end
    end
  end

endmodule

module ecc_host_link #(
  parameter int MAX_BITS = 256,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pa_req,
  output logic                pa_ack_rdy,
  input  logic [1:0]          mode_in,
  input  logic [MAX_BITS-1:0] prime_in,
  input  logic [MAX_BITS-1:0] px_in,
  input  logic [MAX_BITS-1:0] py_in,
  input  logic [MAX_BITS-1:0] a_in,
  input  logic                pb_req,
  output logic                pb_ack_rdy,
  input  logic [MAX_BITS-1:0] pbx_in,
  input  logic [MAX_BITS-1:0] pby_in,
  output logic                s_p_a_valid,
  output logic                s_mode,
  output logic                s_prime,
  output logic                s_px,
  output logic                s_py,
  output logic                s_a,
  output logic                s_pb_valid,
  output logic                s_pbx,
  output logic                s_pby,
  input  logic                r_pa_valid,
  input  logic                r_pax,
  input  logic                r_pay,
  input  logic                r_pab_valid,
  input  logic                r_pabx,
  input  logic                r_paby,
  output logic [MAX_BITS-1:0] pa_x,
  output logic [MAX_BITS-1:0] pa_y,
  output logic                pa_done,
  output logic [MAX_BITS-1:0] pab_x,
  output logic [MAX_BITS-1:0] pab_y,
  output logic                pab_done,
  output logic                frame_err
);

  typedef enum logic [2:0] {IDLE, PA_HDR, MODE, PA_DATA, PB_HDR, PB_DATA} tx_state_t;

  function automatic logic [CNT_W:0] nbits(input logic [1:0] m);
    return (CNT_W+1)'(32) << m;
  endfunction

  function automatic logic [CNT_W:0] shamt(input logic [1:0] m);
    return (CNT_W+1)'(MAX_BITS) - nbits(m);
  endfunction

  tx_state_t           state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [1:0]          cur_mode;
  logic                mode_known, mode_known_n;
  logic                pa_acc, pb_acc;
  logic [MAX_BITS-1:0] sh_prime, sh_px, sh_py, sh_a, sh_pbx, sh_pby;
  logic                pa_trunc, pab_trunc;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pa_acc       = 1'b0;
    pb_acc       = 1'b0;
    mode_known_n = mode_known | (state == MODE);
    case (state)
      IDLE: begin
        if (pa_req && pa_ack_rdy) begin
          pa_acc  = 1'b1;
          state_n = PA_HDR;
        end else if (pb_req && pb_ack_rdy) begin
          pb_acc  = 1'b1;
          state_n = PB_HDR;
        end
      end
      PA_HDR: begin
        state_n = MODE;
        cnt_n   = '0;
      end
      MODE: begin
        if (cnt[0]) begin
          state_n = PA_DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PA_DATA, PB_DATA: begin
        if ({1'b0, cnt} == (nbits(cur_mode) - (CNT_W+1)'(1))) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PB_HDR: begin
        state_n = PB_DATA;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each line lines up with the state it belongs to.
  // Operands are left-aligned at load so the MSB of the N-bit field is always at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_mode    <= '0;
      mode_known  <= 1'b0;
      sh_prime    <= '0;
      sh_px       <= '0;
      sh_py       <= '0;
      sh_a        <= '0;
      sh_pbx      <= '0;
      sh_pby      <= '0;
      pa_ack_rdy  <= 1'b0;
      pb_ack_rdy  <= 1'b0;
      s_p_a_valid <= 1'b0;
      s_mode      <= 1'b0;
      s_prime     <= 1'b0;
      s_px        <= 1'b0;
      s_py        <= 1'b0;
      s_a         <= 1'b0;
      s_pb_valid  <= 1'b0;
      s_pbx       <= 1'b0;
      s_pby       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mode_known <= mode_known_n;
      if (pa_acc) begin
        cur_mode <= mode_in;
        sh_prime <= prime_in << shamt(mode_in);
        sh_px    <= px_in << shamt(mode_in);
        sh_py    <= py_in << shamt(mode_in);
        sh_a     <= a_in << shamt(mode_in);
      end else if (state_n == PA_DATA) begin
        sh_prime <= sh_prime << 1;
        sh_px    <= sh_px << 1;
        sh_py    <= sh_py << 1;
        sh_a     <= sh_a << 1;
      end
      if (pb_acc) begin
        sh_pbx <= pbx_in << shamt(cur_mode);
        sh_pby <= pby_in << shamt(cur_mode);
      end else if (state_n == PB_DATA) begin
        sh_pbx <= sh_pbx << 1;
        sh_pby <= sh_pby << 1;
      end
      pa_ack_rdy  <= (state_n == IDLE);
      pb_ack_rdy  <= (state_n == IDLE) && mode_known_n;
      s_p_a_valid <= (state_n == PA_HDR);
      s_pb_valid  <= (state_n == PB_HDR);
      s_mode      <= (state_n == MODE) ? ((state == PA_HDR) ? cur_mode[1] : cur_mode[0]) : 1'b0;
      s_prime     <= (state_n == PA_DATA) ? sh_prime[MAX_BITS-1] : 1'b0;
      s_px        <= (state_n == PA_DATA) ? sh_px[MAX_BITS-1] : 1'b0;
      s_py        <= (state_n == PA_DATA) ? sh_py[MAX_BITS-1] : 1'b0;
      s_a         <= (state_n == PA_DATA) ? sh_a[MAX_BITS-1] : 1'b0;
      s_pbx       <= (state_n == PB_DATA) ? sh_pbx[MAX_BITS-1] : 1'b0;
      s_pby       <= (state_n == PB_DATA) ? sh_pby[MAX_BITS-1] : 1'b0;
      frame_err   <= frame_err | pa_trunc | pab_trunc;
    end
  end

  ecc_rx_deser #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_rx_pa (
    .clk      (clk),
    .rst      (rst),
    .cur_mode (cur_mode),
    .valid    (r_pa_valid),
    .bit_x    (r_pax),
    .bit_y    (r_pay),
    .res_x    (pa_x),
    .res_y    (pa_y),
    .done     (pa_done),
    .trunc    (pa_trunc)
  );

  ecc_rx_deser #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_rx_pab (
    .clk      (clk),
    .rst      (rst),
    .cur_mode (cur_mode),
    .valid    (r_pab_valid),
    .bit_x    (r_pabx),
    .bit_y    (r_paby),
    .res_x    (pab_x),
    .res_y    (pab_y),
    .done     (pab_done),
    .trunc    (pab_trunc)
  );

endmodule

// File: tb/tb_ecc_host_link.sv
// Scoreboard bench for ecc_host_link: drivers queue expected frames/results, monitors pop and compare.
module tb_ecc_host_link;
  localparam int MB = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic pa_req, pa_ack_rdy, pb_req, pb_ack_rdy;
  logic [1:0] mode_in;
  logic [MB-1:0] prime_in, px_in, py_in, a_in, pbx_in, pby_in;
  logic s_p_a_valid, s_mode, s_prime, s_px, s_py, s_a, s_pb_valid, s_pbx, s_pby;
  logic r_pa_valid, r_pax, r_pay, r_pab_valid, r_pabx, r_paby;
  logic [MB-1:0] pa_x, pa_y, pab_x, pab_y;
  logic pa_done, pab_done, frame_err;

  ecc_host_link #(.MAX_BITS(MB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pa_req(pa_req), .pa_ack_rdy(pa_ack_rdy), .mode_in(mode_in),
    .prime_in(prime_in), .px_in(px_in), .py_in(py_in), .a_in(a_in),
    .pb_req(pb_req), .pb_ack_rdy(pb_ack_rdy), .pbx_in(pbx_in), .pby_in(pby_in),
    .s_p_a_valid(s_p_a_valid), .s_mode(s_mode), .s_prime(s_prime), .s_px(s_px),
    .s_py(s_py), .s_a(s_a), .s_pb_valid(s_pb_valid), .s_pbx(s_pbx), .s_pby(s_pby),
    .r_pa_valid(r_pa_valid), .r_pax(r_pax), .r_pay(r_pay),
    .r_pab_valid(r_pab_valid), .r_pabx(r_pabx), .r_paby(r_paby),
    .pa_x(pa_x), .pa_y(pa_y), .pa_done(pa_done),
    .pab_x(pab_x), .pab_y(pab_y), .pab_done(pab_done), .frame_err(frame_err)
  );

  typedef struct {
    bit          is_pa;
    bit [1:0]    mode;
    bit [MB-1:0] w0, w1, w2, w3;
  } frame_t;
  typedef struct {
    bit [MB-1:0] x, y;
  } res_t;

  frame_t tx_q[$];
  res_t   pa_q[$];
  res_t   pab_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit [1:0] m_mode = 2'd0;
  bit m_known = 1'b0;
  bit tx_busy = 1'b0;
  bit [MB-1:0] last_pab_x = '0;

  task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic bit [MB-1:0] mask_n(input bit [1:0] m);
    int n;
    bit [MB-1:0] one;
    n = 32 << m;
    one = 1;
    if (n == MB) return '1;
    return (one << n) - one;
  endfunction

  function automatic bit [MB-1:0] rnd();
    bit [MB-1:0] v;
    for (int i = 0; i < MB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic all_zero(input string name);
    check(name, MB'(|{pa_ack_rdy, pb_ack_rdy, s_p_a_valid, s_mode, s_prime, s_px, s_py, s_a,
                      s_pb_valid, s_pbx, s_pby, pa_x, pa_y, pab_x, pab_y,
                      pa_done, pab_done, frame_err}), '0);
  endtask

  // Issue PA and/or PB requests; expected frames are queued at the cycle each is accepted.
  task automatic issue(input bit do_pa, input bit do_pb, input bit [1:0] m,
                       input bit [MB-1:0] p, input bit [MB-1:0] x, input bit [MB-1:0] y,
                       input bit [MB-1:0] a, input bit [MB-1:0] bx, input bit [MB-1:0] by,
                       output int gap);
    frame_t f;
    bit pa_a, pb_a;
    int pa_t, pb_t;
    pa_t = -1;
    pb_t = -1;
    @(negedge clk);
    mode_in = m; prime_in = p; px_in = x; py_in = y; a_in = a; pbx_in = bx; pby_in = by;
    pa_req = do_pa;
    pb_req = do_pb;
    for (int i = 0; i < 3000 && (pa_req || pb_req); i++) begin
      pa_a = pa_req && pa_ack_rdy;
      pb_a = pb_req && pb_ack_rdy && !pa_a;
      if (pa_a) begin
        m_mode = m;
        m_known = 1'b1;
        f.is_pa = 1'b1; f.mode = m;
        f.w0 = p & mask_n(m); f.w1 = x & mask_n(m); f.w2 = y & mask_n(m); f.w3 = a & mask_n(m);
        tx_q.push_back(f);
        pa_t = i;
      end
      if (pb_a) begin
        check("pb_accept_needs_mode", MB'(m_known), MB'(1));
        f.is_pa = 1'b0; f.mode = m_mode;
        f.w0 = bx & mask_n(m_mode); f.w1 = by & mask_n(m_mode); f.w2 = '0; f.w3 = '0;
        tx_q.push_back(f);
        pb_t = i;
      end
      @(negedge clk);
      if (pa_a) pa_req = 1'b0;
      if (pb_a) pb_req = 1'b0;
    end
    if (pa_req || pb_req) begin
      check("accept_timeout", MB'({pa_req, pb_req}), '0);
      pa_req = 1'b0;
      pb_req = 1'b0;
    end
    gap = pb_t - pa_t;
  endtask

  task automatic rx_send(input bit ch, input int n, input bit [MB-1:0] x, input bit [MB-1:0] y);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!ch) begin r_pa_valid = 1'b1; r_pax = x[n-1-i]; r_pay = y[n-1-i]; end
      else     begin r_pab_valid = 1'b1; r_pabx = x[n-1-i]; r_paby = y[n-1-i]; end
    end
  endtask

  task automatic rx_stop(input bit ch);
    @(negedge clk);
    if (!ch) begin r_pa_valid = 1'b0; r_pax = 1'b0; r_pay = 1'b0; end
    else     begin r_pab_valid = 1'b0; r_pabx = 1'b0; r_paby = 1'b0; end
  endtask

  task automatic rx_frame(input bit ch, input bit [MB-1:0] x, input bit [MB-1:0] y);
    res_t r;
    int n;
    n = 32 << m_mode;
    r.x = x & mask_n(m_mode);
    r.y = y & mask_n(m_mode);
    if (!ch) pa_q.push_back(r);
    else begin pab_q.push_back(r); last_pab_x = r.x; end
    rx_send(ch, n, x, y);
  endtask

  // TX monitor: reassemble each frame the DUT emits and compare with the head of the queue.
  initial begin : tx_mon
    frame_t f;
    bit [MB-1:0] c0, c1, c2, c3;
    bit [1:0] gm;
    bit ab;
    int n;
    forever begin
      @(negedge clk);
      if (!rst && (s_p_a_valid || s_pb_valid)) begin
        if (tx_q.size() == 0) begin
          check("unexpected_tx_frame", MB'({s_p_a_valid, s_pb_valid}), '0);
        end else begin
          f = tx_q.pop_front();
          tx_busy = 1'b1;
          ab = 1'b0;
          c0 = '0; c1 = '0; c2 = '0; c3 = '0; gm = '0;
          check("tx_frame_kind", MB'(s_p_a_valid), MB'(f.is_pa));
          if (f.is_pa) begin
            for (int i = 0; i < 2 && !ab; i++) begin
              @(negedge clk);
              if (rst) ab = 1'b1;
              gm = {gm[0], s_mode};
            end
          end
          n = 32 << f.mode;
          for (int i = 0; i < n && !ab; i++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            if (f.is_pa) begin
              c0 = {c0[MB-2:0], s_prime}; c1 = {c1[MB-2:0], s_px};
              c2 = {c2[MB-2:0], s_py};    c3 = {c3[MB-2:0], s_a};
            end else begin
              c0 = {c0[MB-2:0], s_pbx};   c1 = {c1[MB-2:0], s_pby};
            end
          end
          if (!ab) begin
            if (f.is_pa) begin
              check("tx_mode_bits", MB'(gm), MB'(f.mode));
              check("tx_prime", c0, f.w0);
              check("tx_px", c1, f.w1);
              check("tx_py", c2, f.w2);
              check("tx_a", c3, f.w3);
            end else begin
              check("tx_pbx", c0, f.w0);
              check("tx_pby", c1, f.w1);
            end
            @(negedge clk);
            if (!rst)
              check("tx_idle_after_frame", MB'({s_p_a_valid, s_pb_valid, s_mode, s_prime, s_px,
                                                 s_py, s_a, s_pbx, s_pby}), '0);
          end
          tx_busy = 1'b0;
        end
      end
    end
  end

  initial begin : pa_mon
    res_t r;
    forever begin
      @(negedge clk);
      if (pa_done) begin
        if (pa_q.size() == 0) check("unexpected_pa_done", MB'(pa_done), '0);
        else begin
          r = pa_q.pop_front();
          check("rx_pa_x", pa_x, r.x);
          check("rx_pa_y", pa_y, r.y);
        end
      end
    end
  end

  initial begin : pab_mon
    res_t r;
    forever begin
      @(negedge clk);
      if (pab_done) begin
        if (pab_q.size() == 0) check("unexpected_pab_done", MB'(pab_done), '0);
        else begin
          r = pab_q.pop_front();
          check("rx_pab_x", pab_x, r.x);
          check("rx_pab_y", pab_y, r.y);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int gap, cnt, r;
    bit [1:0] m;
    rst = 1'b1;
    pa_req = 0; pb_req = 0; mode_in = 0;
    prime_in = 0; px_in = 0; py_in = 0; a_in = 0; pbx_in = 0; pby_in = 0;
    r_pa_valid = 0; r_pax = 0; r_pay = 0; r_pab_valid = 0; r_pabx = 0; r_paby = 0;
    repeat (3) @(negedge clk);
    all_zero("reset_outputs_zero");
    rst = 1'b0;
    @(negedge clk);
    check("ack_after_reset", MB'({pa_ack_rdy, pb_ack_rdy}), MB'(2'b10));

    // PB without any prior PA must never be accepted.
    pb_req = 1'b1; pbx_in = rnd(); pby_in = rnd();
    cnt = 0;
    repeat (30) begin @(negedge clk); if (pb_ack_rdy) cnt++; end
    pb_req = 1'b0;
    check("pb_rdy_without_mode", MB'(cnt), '0);

    issue(1, 0, 2'd0, MB'(32'hFFFFFFFB), MB'(32'h12345678), rnd(), MB'(32'h80000001), '0, '0, gap);

    // Simultaneous requests: PA wins, PB follows after the PA frame and one idle cycle.
    issue(1, 1, 2'd1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), gap);
    check("pb_after_pa_gap", MB'(gap), MB'((32 << 1) + 4));

    repeat (8) begin
      r = $urandom_range(0, 2);
      m = 2'($urandom_range(0, 3));
      if (r == 0 || !m_known) issue(1, 0, m, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
      else if (r == 1) issue(0, 1, m, '0, '0, '0, '0, rnd(), rnd(), gap);
      else begin
        issue(1, 1, m, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), gap);
        check("rand_pb_after_pa_gap", MB'(gap), MB'((32 << m) + 4));
      end
    end

    issue(1, 0, 2'd1, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
    rx_frame(0, {4{64'hA5A5A5A5A5A5A5A5}}, rnd());
    rx_stop(0);

    fork
      rx_frame(0, rnd(), rnd());
      rx_frame(1, rnd(), rnd());
    join
    fork
      rx_stop(0);
      rx_stop(1);
    join

    // Back-to-back frames with valid held high throughout.
    rx_frame(1, rnd(), rnd());
    rx_frame(1, rnd(), rnd());
    rx_stop(1);

    // A PA job accepted while an RX frame is in flight only affects the following frame.
    fork
      rx_frame(0, rnd(), rnd());
      issue(1, 0, m_mode + 2'd1, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
    join
    rx_stop(0);
    rx_frame(0, rnd(), rnd());
    rx_stop(0);

    repeat (3) begin
      issue(1, 0, 2'($urandom_range(0, 3)), rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
      r = $urandom_range(0, 1);
      rx_frame(r[0], rnd(), rnd());
      rx_stop(r[0]);
    end
    repeat (3) @(negedge clk);
    check("no_frame_err_yet", MB'(frame_err), '0);

    // Truncated abP frame.
    issue(1, 0, 2'd0, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
    rx_send(1, 10, rnd(), rnd());
    rx_stop(1);
    repeat (3) @(negedge clk);
    check("frame_err_set", MB'(frame_err), MB'(1));
    check("pab_x_kept", pab_x, last_pab_x);

    // Reset in the middle of a mode-3 PA data phase.
    issue(1, 0, 2'd3, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
    cnt = 0;
    while (!s_p_a_valid && cnt < 3000) begin @(negedge clk); cnt++; end
    check("pa_hdr_seen", MB'(s_p_a_valid), MB'(1));
    repeat (103) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    all_zero("midframe_reset_zero");
    m_mode = 2'd0;
    m_known = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ack_after_midframe_reset", MB'({pa_ack_rdy, pb_ack_rdy}), MB'(2'b10));
    issue(1, 0, 2'd2, rnd(), rnd(), rnd(), rnd(), '0, '0, gap);
    issue(0, 1, 2'd0, '0, '0, '0, '0, rnd(), rnd(), gap);
    rx_frame(0, rnd(), rnd());
    rx_stop(0);

    for (int i = 0; i < 5000; i++) begin
      if (tx_q.size() == 0 && !tx_busy && pa_q.size() == 0 && pab_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", MB'(tx_q.size() + pa_q.size() + pab_q.size() + int'(tx_busy)), '0);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
